i2c_slave_rx: RTL and testbench
===============================

// Module: i2c_slave_rx
// PURPOSE
//  I2C target (slave) receiver: far end of the FIFO-fed I2C master's write transfers.
//  Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and
//  receives write data bytes. Each received byte is ACKed and presented on rx_data/rx_valid.
//  Used as the on-chip loopback target and as the receive front end of peer boards. Write-only.
// PARAMETERS
//  SLAVE_ADDR   7'h50  7-bit address this target responds to
//  SYNC_STAGES  2      flip-flops in each SCL/SDA input synchroniser (>=2)
// PORTS
//  clk          in     1  system clock; SCL period must be >= 16 clk periods
//  reset        in     1  synchronous, active-high reset
//  i2c_scl      in     1  I2C clock from bus (no clock stretching)
//  i2c_sda      inout  1  I2C data; driven only low (open-drain), else 1'bz
//  rx_ready     in     1  downstream can accept a byte; sampled at 8th data bit
//  rx_data      out    8  last received data byte, MSB first on bus
//  rx_valid     out    1  one-cycle strobe: rx_data updated this cycle
//  busy         out    1  bus busy: high from START to STOP
//  addressed    out    1  high from address ACK to STOP or repeated START
// BEHAVIOUR
//  - Reset: state IDLE, SDA released (z), rx_data=8'h00, rx_valid=0, busy=0, addressed=0,
//    bit counter 0. Reset mid-transfer aborts immediately; no further ACK driven.
//  - Inputs pass SYNC_STAGES FFs then one history FF; edges from synchronised values only.
//  - START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Checked every cycle, any state.
//  - START (incl. repeated) in any state -> ADDR, bit counter=0, SDA released, addressed=0, busy=1.
//  - STOP in any state -> IDLE, SDA released, busy=0, addressed=0. STOP wins if same cycle.
//  - Bits sampled on SCL rising edge into shift register, MSB first; counter 0..7.
//  - States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
//    IDLE: wait for START.
//    ADDR: after 8th rising edge, compare byte[7:1]==SLAVE_ADDR and byte[0]==0 (write).
//      Match -> ADDR_ACK. Mismatch or read bit -> WAIT_STOP; SDA never driven.
//    ADDR_ACK: pull SDA low from next SCL falling edge; release at following SCL falling edge;
//      addressed=1 from that release; -> DATA, counter=0.
//    DATA: after 8th rising edge: if rx_ready=1, rx_data<=byte, rx_valid=1 for exactly the
//      next clk cycle, -> DATA_ACK. If rx_ready=0: byte dropped, no strobe, SDA left
//      released (NACK), -> WAIT_STOP.
//    DATA_ACK: same ACK timing as ADDR_ACK; -> DATA, counter=0 (unbounded byte count).
//    WAIT_STOP: ignore SCL; only START/STOP leave this state.
//  - rx_valid latency: 1 clk after the synchronised 8th SCL rising edge is detected.
//  - rx_data holds its value until the next accepted byte.
//  - SDA high during own ACK bit not checked; target never drives during master bits.
//  - A START/STOP mid-byte discards the partial byte.
// TESTING
//  1 reset=1 for 3 clk mid-ACK -> SDA z next cycle, all outputs at reset values, IDLE.
//  2 START, addr 0x50+W, data 0xA5, STOP (rx_ready=1) -> ACK on 9th clocks of both bytes,
//    one rx_valid pulse with rx_data=0xA5, busy 1->0 at STOP, addressed 0 after STOP.
//  3 START, addr 0x51+W, 0x3C -> SDA never driven, no rx_valid, addressed stays 0.
//  4 START, addr 0x50+R -> NACK (SDA z on 9th clock), WAIT_STOP, no rx_valid.
//  5 addr 0x50+W, bytes 0x01,0x02,0x03, rx_ready=0 during 0x02 -> 0x01 ACKed+strobed,
//    0x02 NACKed, 0x03 ignored, exactly one rx_valid pulse.
//  6 addr 0x50+W, 0x11, repeated START, addr 0x50+W, 0x22, STOP -> two strobes 0x11 then
//    0x22; busy stays 1 through Sr; addressed drops at Sr, rises at second address ACK.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match, ACKed data bytes presented as a one-cycle strobe.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addressed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   ack_drive_q, ack_drive_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   addressed_q, addressed_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP.
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign byte_in   = {shift_q[6:0], sda_s};

    assign i2c_sda   = ack_drive_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;

    always_comb begin
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
        scl_hist_d  = scl_s;
        sda_hist_d  = sda_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ack_drive_d = ack_drive_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        busy_d      = busy_q;
        addressed_d = addressed_q;

        case (state_q)
            S_ADDR: begin
                if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (byte_in[7:1] == SLAVE_ADDR && !byte_in[0]) begin
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                // First falling edge starts the ACK bit, the second one ends it.
                if (scl_fall) begin
                    if (!ack_drive_q) begin
                        ack_drive_d = 1'b1;
                    end else begin
                        ack_drive_d = 1'b0;
                        addressed_d = 1'b1;
                        state_d     = S_DATA;
                        bit_cnt_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (rx_ready) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = S_DATA_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase

        if (stop_det) begin
            state_d     = S_IDLE;
            bit_cnt_d   = 3'd0;
            ack_drive_d = 1'b0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
        end else if (start_det) begin
            state_d     = S_ADDR;
            bit_cnt_d   = 3'd0;
            ack_drive_d = 1'b0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_hist_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ack_drive_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_hist_q  <= scl_hist_d;
            sda_hist_q  <= sda_hist_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ack_drive_q <= ack_drive_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            addressed_q <= addressed_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master with an expected-byte queue
// checked against every rx_valid strobe.
module tb_i2c_slave_rx;

    localparam int Q = 5;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic       rx_ready = 1'b1;
    wire        sda_bus;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        busy;
    wire        addressed;

    int         checks = 0;
    int         failures = 0;
    int         strobes = 0;
    int         drive_errs = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_valid = 1'b0;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .i2c_scl(scl),
        .i2c_sda(sda_bus),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .addressed(addressed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected: got rx_data=%02h, required no strobe", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rx_data !== mon_exp) begin
                    failures++;
                    $display("FAIL rx_data: got %02h, required %02h", rx_data, mon_exp);
                end else begin
                    $display("rx strobe data=%02h", rx_data);
                end
            end
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL rx_valid_width: got 2+ cycles, required 1");
            end
        end
        prev_valid = rx_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_low = 1'b1; wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_low = 1'b0; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        if (b && sda_bus !== 1'b1) drive_errs++;
        wait_clk(Q);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        sda_low = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        acked = (sda_bus === 1'b0);
        wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
        $display("byte %02h sent, ack=%0b", v, acked);
    endtask

    task automatic test_reset();
        reset = 1'b1; wait_clk(3);
        checks++;
        if ({busy, addressed, rx_valid, rx_data, sda_bus} !== {3'b000, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got busy=%0b addr=%0b vld=%0b data=%02h sda=%0b, required 0 0 0 00 1",
                     busy, addressed, rx_valid, rx_data, sda_bus);
        end
        reset = 1'b0; wait_clk(4);
    endtask

    task automatic test_write();
        logic ack;
        int   s0;
        s0 = strobes;
        i2c_start();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_start: got %0b, required 1", busy); end
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL write_addr_ack: got %0b, required 1", ack); end
        checks++;
        if (addressed !== 1'b1) begin failures++; $display("FAIL write_addressed: got %0b, required 1", addressed); end
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL write_data_ack: got %0b, required 1", ack); end
        i2c_stop(); wait_clk(4);
        checks++;
        if ({busy, addressed} !== 2'b00) begin
            failures++;
            $display("FAIL write_after_stop: got busy=%0b addressed=%0b, required 0 0", busy, addressed);
        end
        checks++;
        if (strobes - s0 != 1) begin failures++; $display("FAIL write_strobes: got %0d, required 1", strobes - s0); end
    endtask

    task automatic test_reset_mid_ack();
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
        sda_low = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        checks++;
        if (sda_bus !== 1'b0) begin failures++; $display("FAIL midack_driving: got sda=%0b, required 0", sda_bus); end
        reset = 1'b1; wait_clk(1);
        checks++;
        if (sda_bus !== 1'b1) begin failures++; $display("FAIL midack_release: got sda=%0b, required 1", sda_bus); end
        wait_clk(2);
        checks++;
        if ({busy, addressed, rx_valid, rx_data} !== {3'b000, 8'h00}) begin
            failures++;
            $display("FAIL midack_reset_outputs: got busy=%0b addr=%0b vld=%0b data=%02h, required 0 0 0 00",
                     busy, addressed, rx_valid, rx_data);
        end
        reset = 1'b0; wait_clk(Q);
        scl = 1'b0;   wait_clk(Q);
        i2c_stop();   wait_clk(4);
        $display("reset mid-ACK applied");
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int   s0;
        s0 = strobes;
        i2c_start();
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL wrong_addr_ack: got %0b, required 0", ack); end
        send_byte(8'h3C, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL wrong_data_ack: got %0b, required 0", ack); end
        checks++;
        if (addressed !== 1'b0) begin failures++; $display("FAIL wrong_addressed: got %0b, required 0", addressed); end
        i2c_stop(); wait_clk(4);
        checks++;
        if (strobes != s0) begin failures++; $display("FAIL wrong_strobes: got %0d, required 0", strobes - s0); end
    endtask

    task automatic test_read_nack();
        logic ack;
        int   s0;
        s0 = strobes;
        i2c_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL read_addr_ack: got %0b, required 0", ack); end
        send_byte(8'hFF, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL read_wait_stop_ack: got %0b, required 0", ack); end
        i2c_stop(); wait_clk(4);
        checks++;
        if (strobes != s0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL read_end: got strobes=%0d busy=%0b, required 0 0", strobes - s0, busy);
        end
    endtask

    task automatic test_not_ready();
        logic ack;
        int   s0;
        s0 = strobes;
        i2c_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h01);
        send_byte(8'h01, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL nready_first_ack: got %0b, required 1", ack); end
        rx_ready = 1'b0;
        send_byte(8'h02, ack);
        rx_ready = 1'b1;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL nready_drop_ack: got %0b, required 0", ack); end
        send_byte(8'h03, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL nready_ignored_ack: got %0b, required 0", ack); end
        i2c_stop(); wait_clk(4);
        checks++;
        if (strobes - s0 != 1) begin failures++; $display("FAIL nready_strobes: got %0d, required 1", strobes - s0); end
    endtask

    task automatic test_back_to_back();
        logic ack;
        int   s0;
        s0 = strobes;
        i2c_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h11);
        send_byte(8'h11, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL rs_first_ack: got %0b, required 1", ack); end
        i2c_start();
        checks++;
        if ({busy, addressed} !== 2'b10) begin
            failures++;
            $display("FAIL rs_after_sr: got busy=%0b addressed=%0b, required 1 0", busy, addressed);
        end
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b1 || addressed !== 1'b1) begin
            failures++;
            $display("FAIL rs_second_addr: got ack=%0b addressed=%0b, required 1 1", ack, addressed);
        end
        exp_q.push_back(8'h22);
        send_byte(8'h22, ack);
        i2c_stop(); wait_clk(4);
        checks++;
        if (strobes - s0 != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rs_end: got strobes=%0d busy=%0b, required 2 0", strobes - s0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_reset_mid_ack();
        test_wrong_addr();
        test_read_nack();
        test_not_ready();
        test_back_to_back();
        wait_clk(10);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        checks++;
        if (drive_errs != 0) begin failures++; $display("FAIL master_bit_drive: got %0d, required 0", drive_errs); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
